// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and state encoding for the write-back register file
package rf_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/rf_clear_ctrl.sv
// rf_clear_ctrl: clear sequencer that zeroes one register per cycle and qualifies writes
//   clk, reset  : clock, synchronous active-high reset
//   we, clr_req : write request and clear request from the datapath
//   clr_en      : array must zero entry clr_idx at the next edge
//   clr_idx     : register being cleared this cycle
//   wr_ok       : write request is accepted (IDLE only)
//   busy        : registered, high while the sequence runs
//   wr_drop     : registered one-cycle pulse after a discarded write
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int AW = rf_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          clr_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          wr_ok,
    output logic          busy,
    output logic          wr_drop
);
    localparam logic [AW-1:0] LAST = AW'(2 ** AW - 1);
    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state == CLEAR) ? cnt + 1'b1 : '0;
            wr_drop <= (state == CLEAR) && we;
        end
    end
    // clr_req is only looked at in IDLE, so a request held through the last
    // CLEAR edge cannot extend or restart the sequence
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = clr_req ? CLEAR : IDLE;
        else
            state_nxt = (cnt == LAST) ? IDLE : CLEAR;
    end
    // busy comes straight from the state flop, so it is a registered output
    always_comb begin
        busy    = state == CLEAR;
        clr_en  = state == CLEAR;
        clr_idx = cnt;
        wr_ok   = (state == IDLE) && we;
    end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 8x16 write-back register file, one sync write port, two comb read ports, clear sequencer
//   clk, reset          : clock, synchronous active-high reset
//   we, w_addr, w_data  : write port fed by the write-back mux
//   r_addr_a, r_addr_b  : read indices; rd_a, rd_b combinational read data
//   clr_req             : start a clear sequence; busy high while it runs
//   wr_drop             : one-cycle pulse after a write discarded during a clear
//   REGFILE_BYPASS_EN   : when defined, accepted writes are forwarded to matching read ports
module reg_file_wb #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);
    logic [DATA_W-1:0] regs [2 ** ADDR_W];
    logic              clr_en, wr_ok;
    logic [ADDR_W-1:0] clr_idx;
    rf_clear_ctrl #(.AW(ADDR_W)) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .clr_req (clr_req),
        .clr_en  (clr_en),
        .clr_idx (clr_idx),
        .wr_ok   (wr_ok),
        .busy    (busy),
        .wr_drop (wr_drop)
    );
    // wr_ok is never high during CLEAR, so the two branches never compete
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2 ** ADDR_W; i++) regs[i] <= '0;
        end else if (clr_en) begin
            regs[clr_idx] <= '0;
        end else if (wr_ok) begin
            regs[w_addr] <= w_data;
        end
    end
`ifdef REGFILE_BYPASS_EN
    assign rd_a = (wr_ok && w_addr == r_addr_a) ? w_data : regs[r_addr_a];
    assign rd_b = (wr_ok && w_addr == r_addr_b) ? w_data : regs[r_addr_b];
`else
    assign rd_a = regs[r_addr_a];
    assign rd_b = regs[r_addr_b];
`endif
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        reset, we, clr_req;
    logic [2:0]  w_addr, r_addr_a, r_addr_b;
    logic [15:0] w_data, rd_a, rd_b;
    logic        busy, wr_drop;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    reg_file_wb dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_addr_a (r_addr_a),
        .r_addr_b (r_addr_b),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; w_addr = a; w_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; we = 1'b0; clr_req = 1'b0;
        w_addr = '0; w_data = '0; r_addr_a = '0; r_addr_b = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_addr_a = 3'(i); r_addr_b = 3'(7 - i);
            #1;
            n_vec++;
            if (rd_a !== 16'h0000) begin n_err++; $display("FAIL reset_rd_a[%0d] got %h exp 0000", i, rd_a); end
            n_vec++;
            if (rd_b !== 16'h0000) begin n_err++; $display("FAIL reset_rd_b[%0d] got %h exp 0000", 7 - i, rd_b); end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++;
        if (wr_drop !== 1'b0) begin n_err++; $display("FAIL reset_wr_drop got %b exp 0", wr_drop); end
    endtask

    task automatic test_write;
        logic [15:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'hA5A5;
`else
        exp_same = 16'h0000;
`endif
        we = 1'b1; w_addr = 3'd3; w_data = 16'hA5A5; r_addr_a = 3'd3;
        #1;
        n_vec++;
        if (rd_a !== exp_same) begin n_err++; $display("FAIL same_cycle_r3 got %h exp %h", rd_a, exp_same); end
        tick();
        wr(3'd7, 16'h1234);
        r_addr_a = 3'd3; r_addr_b = 3'd7;
        #1;
        n_vec++;
        if (rd_a !== 16'hA5A5) begin n_err++; $display("FAIL write_r3 got %h exp a5a5", rd_a); end
        n_vec++;
        if (rd_b !== 16'h1234) begin n_err++; $display("FAIL write_r7 got %h exp 1234", rd_b); end
    endtask

    task automatic test_clear;
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h0011 * i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy_start got %b exp 1", busy); end
        for (int e = 1; e <= 8; e++) begin
            tick();
            r_addr_a = 3'(e - 1); r_addr_b = 3'(e);
            #1;
            n_vec++;
            if (busy !== (e < 8)) begin n_err++; $display("FAIL clear_busy_e%0d got %b exp %b", e, busy, e < 8); end
            n_vec++;
            if (rd_a !== 16'h0000) begin n_err++; $display("FAIL clear_done_r%0d got %h exp 0000", e - 1, rd_a); end
            if (e < 8) begin
                n_vec++;
                if (rd_b !== 16'(16'h0011 * e)) begin n_err++; $display("FAIL clear_pending_r%0d got %h exp %h", e, rd_b, 16'(16'h0011 * e)); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            r_addr_a = 3'(i);
            #1;
            n_vec++;
            if (rd_a !== 16'h0000) begin n_err++; $display("FAIL clear_all_r%0d got %h exp 0000", i, rd_a); end
        end
    endtask

    task automatic test_drop;
        wr(3'd2, 16'h2222);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        we = 1'b1; w_addr = 3'd2; w_data = 16'hFFFF; r_addr_a = 3'd2;
        #1;
        n_vec++;
        if (rd_a !== 16'h2222) begin n_err++; $display("FAIL drop_no_forward got %h exp 2222", rd_a); end
        n_vec++;
        if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_before got %b exp 0", wr_drop); end
        tick();
        we = 1'b0;
        n_vec++;
        if (wr_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse got %b exp 1", wr_drop); end
        tick();
        n_vec++;
        if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_pulse_end got %b exp 0", wr_drop); end
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_end got %b exp 0", busy); end
        n_vec++;
        if (rd_a !== 16'h0000) begin n_err++; $display("FAIL drop_r2 got %h exp 0000", rd_a); end
    endtask

    task automatic test_back_to_back;
        clr_req = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got %b exp 0", busy); end
        tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got %b exp 1", busy); end
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_second_end got %b exp 0", busy); end
    endtask

    task automatic test_simul;
        we = 1'b1; w_addr = 3'd5; w_data = 16'hBEEF; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0; r_addr_a = 3'd5;
        #1;
        n_vec++;
        if (rd_a !== 16'hBEEF) begin n_err++; $display("FAIL simul_commit got %h exp beef", rd_a); end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL simul_busy got %b exp 1", busy); end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_vec++;
            if (rd_a !== (e >= 6 ? 16'h0000 : 16'hBEEF)) begin
                n_err++; $display("FAIL simul_r5_e%0d got %h exp %h", e, rd_a, e >= 6 ? 16'h0000 : 16'hBEEF);
            end
        end
    endtask

    task automatic test_reset_mid;
        wr(3'd6, 16'h6666);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1; we = 1'b1; w_addr = 3'd6; w_data = 16'h7777; clr_req = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0; clr_req = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_vec++;
        if (wr_drop !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_drop got %b exp 0", wr_drop); end
        for (int i = 0; i < 8; i++) begin
            r_addr_a = 3'(i);
            #1;
            n_vec++;
            if (rd_a !== 16'h0000) begin n_err++; $display("FAIL rstmid_r%0d got %h exp 0000", i, rd_a); end
        end
        wr(3'd1, 16'h0101);
        r_addr_a = 3'd1;
        #1;
        n_vec++;
        if (rd_a !== 16'h0101) begin n_err++; $display("FAIL rstmid_write_r1 got %h exp 0101", rd_a); end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_clear();
        test_drop();
        test_back_to_back();
        test_simul();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
